// File: rtl/write_once_reg_arbiter.sv
// Round-robin arbiter sharing one write-once config register; bit 0 of a committed write is a sticky lock.
// Latency: grant the cycle after req, ack/nack two cycles after grant; requests are level-held until ack/nack.
module write_once_reg_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16
) (
  input  logic                      Clk,
  input  logic                      ip_reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  input  logic                      unlock,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        nack,
  output logic [DATA_W-1:0]         Data_out,
  output logic                      locked,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, COMMIT, RELEASE} state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   win_idx;
  logic [DATA_W-1:0]  wbuf;

  logic               arb_found;
  logic [IDX_W-1:0]   arb_idx;
  logic [IDX_W-1:0]   arb_next;

  // Search downward so the lowest offset from the pointer is the last (winning) assignment.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % NUM_REQ]) begin
        arb_found = 1'b1;
        arb_idx   = IDX_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end

  assign arb_next = IDX_W'((int'(arb_idx) + 1) % NUM_REQ);
  assign busy     = (state != IDLE);

  always_ff @(posedge Clk) begin
    if (ip_reset) begin
      state    <= IDLE;
      ptr      <= '0;
      win_idx  <= '0;
      wbuf     <= '0;
      gnt      <= '0;
      ack      <= '0;
      nack     <= '0;
      Data_out <= '0;
      locked   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (unlock) begin
            locked      <= 1'b0;
            Data_out[0] <= 1'b0;
          end else if (arb_found) begin
            gnt[arb_idx] <= 1'b1;
            win_idx      <= arb_idx;
            ptr          <= arb_next;
            state        <= GRANT;
          end
        end
        GRANT: begin
          wbuf  <= wdata[int'(win_idx)*DATA_W +: DATA_W];
          gnt   <= '0;
          // A requester that let go during its grant forfeits the slot silently.
          state <= req[win_idx] ? COMMIT : IDLE;
        end
        COMMIT: begin
          if (!locked) begin
            Data_out     <= wbuf;
            locked       <= wbuf[0];
            ack[win_idx] <= 1'b1;
          end else begin
            nack[win_idx] <= 1'b1;
          end
          state <= RELEASE;
        end
        RELEASE: begin
          ack  <= '0;
          nack <= '0;
          if (!req[win_idx]) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_write_once_reg_arbiter.sv
// Scoreboard bench: a queue-level reference model predicts grants and responses; a monitor pops and compares.
module tb_write_once_reg_arbiter;
  localparam int N      = 4;
  localparam int W      = 16;
  localparam int BUDGET = 200;

  logic           Clk, ip_reset, unlock;
  logic [N-1:0]   req, gnt, ack, nack;
  logic [N*W-1:0] wdata;
  logic [W-1:0]   Data_out;
  logic           locked, busy;

  typedef struct packed {
    logic [N-1:0] ack;
    logic [N-1:0] nack;
    logic [W-1:0] dout;
    logic         lk;
  } resp_t;

  logic [N-1:0] exp_gnt_q[$];
  resp_t        exp_resp_q[$];
  logic [W-1:0] tq [N][$];

  int           m_ptr;
  logic [W-1:0] m_data;
  logic         m_locked;
  int           n_checks, n_fail;

  write_once_reg_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
    .Clk(Clk), .ip_reset(ip_reset), .req(req), .wdata(wdata), .unlock(unlock),
    .gnt(gnt), .ack(ack), .nack(nack), .Data_out(Data_out), .locked(locked), .busy(busy)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Serialises all queued writes: every requester with data left is pending at each arbitration.
  task automatic model_batch(input bit do_unlock, output logic [W-1:0] u_data, output logic u_locked);
    int pos[N];
    bit more;
    if (do_unlock) begin
      m_locked  = 1'b0;
      m_data[0] = 1'b0;
    end
    u_data   = m_data;
    u_locked = m_locked;
    for (int i = 0; i < N; i++) pos[i] = 0;
    more = 1'b1;
    while (more) begin
      int w;
      w = -1;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (w < 0 && pos[c] < tq[c].size()) w = c;
      end
      if (w < 0) begin
        more = 1'b0;
      end else begin
        logic [W-1:0] d;
        logic [N-1:0] oh;
        resp_t r;
        d = tq[w][pos[w]];
        pos[w]++;
        oh = '0;
        oh[w] = 1'b1;
        exp_gnt_q.push_back(oh);
        r = '0;
        if (!m_locked) begin
          m_data   = d;
          m_locked = d[0];
          r.ack    = oh;
        end else begin
          r.nack = oh;
        end
        r.dout = m_data;
        r.lk   = m_locked;
        exp_resp_q.push_back(r);
        m_ptr = (w + 1) % N;
      end
    end
  endtask

  task automatic run_batch(input bit do_unlock);
    logic [W-1:0] u_data;
    logic         u_locked;
    logic [N-1:0] reass;
    int           cycles;
    model_batch(do_unlock, u_data, u_locked);
    @(negedge Clk);
    unlock = do_unlock;
    reass  = '0;
    for (int i = 0; i < N; i++) begin
      if (tq[i].size() > 0) begin
        wdata[i*W +: W] = tq[i].pop_front();
        req[i] = 1'b1;
      end
    end
    if (do_unlock) begin
      @(negedge Clk);
      unlock = 1'b0;
      check("unlock_data", 32'(Data_out), 32'(u_data));
      check("unlock_locked", 32'(locked), 32'(u_locked));
    end
    cycles = 0;
    while ((req != '0 || busy || reass != '0) && cycles < BUDGET) begin
      @(negedge Clk);
      cycles++;
      for (int i = 0; i < N; i++) begin
        if (reass[i]) begin
          wdata[i*W +: W] = tq[i].pop_front();
          req[i]   = 1'b1;
          reass[i] = 1'b0;
        end else if (ack[i] || nack[i]) begin
          req[i] = 1'b0;
          if (tq[i].size() > 0) reass[i] = 1'b1;
        end
      end
    end
    check("batch_done", 32'(cycles < BUDGET), 32'(1));
    req = '0;
    for (int i = 0; i < N; i++) tq[i].delete();
    check("batch_data", 32'(Data_out), 32'(m_data));
    check("batch_locked", 32'(locked), 32'(m_locked));
  endtask

  task automatic do_reset();
    ip_reset = 1'b1;
    req      = '0;
    unlock   = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_ack", 32'(ack), 32'(0));
    check("rst_nack", 32'(nack), 32'(0));
    check("rst_data", 32'(Data_out), 32'(0));
    check("rst_locked", 32'(locked), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    ip_reset = 1'b0;
    m_ptr    = 0;
    m_data   = '0;
    m_locked = 1'b0;
  endtask

  task automatic wait_gnt(output int cycles);
    cycles = 0;
    do begin
      @(negedge Clk);
      cycles++;
    end while (gnt == '0 && cycles < 10);
  endtask

  task automatic abandon(input int idx);
    logic [N-1:0] oh;
    int cycles;
    oh = '0;
    oh[idx] = 1'b1;
    exp_gnt_q.push_back(oh);
    m_ptr = (idx + 1) % N;
    @(negedge Clk);
    wdata[idx*W +: W] = W'($urandom);
    req[idx] = 1'b1;
    wait_gnt(cycles);
    req[idx] = 1'b0;
    check("abandon_gnt_seen", 32'(cycles < 10), 32'(1));
    repeat (4) @(negedge Clk);
    check("abandon_busy", 32'(busy), 32'(0));
    check("abandon_data", 32'(Data_out), 32'(m_data));
    check("abandon_locked", 32'(locked), 32'(m_locked));
  endtask

  task automatic midop_reset(input int idx);
    logic [N-1:0] oh;
    int cycles;
    oh = '0;
    oh[idx] = 1'b1;
    exp_gnt_q.push_back(oh);
    @(negedge Clk);
    wdata[idx*W +: W] = 16'h5A5B;
    req[idx] = 1'b1;
    wait_gnt(cycles);
    check("midop_gnt_seen", 32'(cycles < 10), 32'(1));
    @(negedge Clk);
    ip_reset = 1'b1;
    @(negedge Clk);
    check("midop_gnt", 32'(gnt), 32'(0));
    check("midop_ack", 32'(ack), 32'(0));
    check("midop_nack", 32'(nack), 32'(0));
    check("midop_busy", 32'(busy), 32'(0));
    check("midop_data", 32'(Data_out), 32'(0));
    check("midop_locked", 32'(locked), 32'(0));
    req      = '0;
    ip_reset = 1'b0;
    m_ptr    = 0;
    m_data   = '0;
    m_locked = 1'b0;
  endtask

  task automatic monitor();
    forever begin
      @(negedge Clk);
      check("onehot_out", 32'(($countones(gnt) + $countones(ack) + $countones(nack)) <= 1), 32'(1));
      if (gnt != '0) begin
        if (exp_gnt_q.size() == 0) check("unexpected_gnt", 32'(gnt), 32'(0));
        else check("gnt", 32'(gnt), 32'(exp_gnt_q.pop_front()));
      end
      if ((ack | nack) != '0) begin
        if (exp_resp_q.size() == 0) begin
          check("unexpected_resp", 32'({ack, nack}), 32'(0));
        end else begin
          resp_t r;
          r = exp_resp_q.pop_front();
          check("ack", 32'(ack), 32'(r.ack));
          check("nack", 32'(nack), 32'(r.nack));
          check("resp_data", 32'(Data_out), 32'(r.dout));
          check("resp_locked", 32'(locked), 32'(r.lk));
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    req      = '0;
    wdata    = '0;
    unlock   = 1'b0;
    ip_reset = 1'b1;
    do_reset();
    fork
      monitor();
    join_none

    tq[1].push_back(16'hA5A4); run_batch(1'b0);
    tq[0].push_back(16'h1235); run_batch(1'b0);
    tq[2].push_back(16'hFFFE); run_batch(1'b0);
    run_batch(1'b1);
    tq[0].push_back(16'h00F1); run_batch(1'b0);
    tq[3].push_back(16'h0002); run_batch(1'b1);

    do_reset();
    for (int i = 0; i < N; i++)
      for (int r = 0; r < 2; r++) tq[i].push_back(W'($urandom) & 16'hFFFE);
    run_batch(1'b0);

    abandon(1);
    for (int i = 0; i < N; i++) tq[i].push_back(W'($urandom) & 16'hFFFE);
    run_batch(1'b0);

    midop_reset(2);

    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < N; i++) begin
        int n;
        n = int'($urandom_range(0, 2));
        for (int r = 0; r < n; r++) tq[i].push_back(W'($urandom));
      end
      run_batch($urandom_range(0, 2) == 0);
    end

    repeat (3) @(negedge Clk);
    check("gnt_queue_drained", 32'(exp_gnt_q.size()), 32'(0));
    check("resp_queue_drained", 32'(exp_resp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/write_once_reg_arbiter.md
Name: write_once_reg_arbiter

Overview:
- Shares one 16-bit write-once configuration register between NUM_REQ independent requesters (CPU port, debug port, boot loader, ...).
- Round-robin arbitration; one write at a time; each write sequenced as grant -> commit -> response.
- Bit 0 of a committed write sets a sticky lock. While locked, all later writes are refused with nack until a privileged unlock or reset.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 16, register width (>= 2).

Ports:
- Clk, input, 1, single clock; all logic on rising edge.
- ip_reset, input, 1, synchronous active-high reset.
- req, input, NUM_REQ, per-requester write request. Level signal, held until ack or nack.
- wdata, input, NUM_REQ*DATA_W, per-requester write data. Requester i uses slice [i*DATA_W +: DATA_W].
- unlock, input, 1, privileged lock clear (one-cycle pulse).
- gnt, output, NUM_REQ, one-hot grant, registered.
- ack, output, NUM_REQ, one-cycle write-accepted pulse.
- nack, output, NUM_REQ, one-cycle write-refused pulse.
- Data_out, output, DATA_W, register contents. Bit 0 mirrors locked.
- locked, output, 1, sticky lock flag.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset (ip_reset=1 at a rising edge):
  - state=IDLE; Data_out=0; locked=0; gnt/ack/nack=0.
  - Round-robin pointer=0, so requester 0 has highest priority first.
  - Reset mid-operation aborts with no ack/nack issued.
- FSM states: IDLE, GRANT, COMMIT, RELEASE.
- IDLE:
  - If unlock=1: locked<=0, Data_out[0]<=0, Data_out[DATA_W-1:1] unchanged. Stay in IDLE; arbitration deferred one cycle. unlock wins over simultaneous req.
  - Else if any req bit is set:
    - Winner = first set req at or after the pointer, searching upward with wrap-around.
    - gnt<=onehot(winner); pointer<=winner+1 (mod NUM_REQ); next state GRANT.
- GRANT (gnt high this cycle):
  - Sample wdata of the winner into an internal buffer.
  - If req[winner] has dropped, the request is abandoned: gnt<=0, no response, return to IDLE.
  - Otherwise gnt<=0, next state COMMIT.
- COMMIT:
  - If locked=0:
    - Data_out<={buf[DATA_W-1:1], buf[0]}; locked<=buf[0].
    - ack[winner]<=1 for one cycle.
  - If locked=1: Data_out unchanged; nack[winner]<=1 for one cycle.
  - Next state RELEASE.
- RELEASE:
  - ack/nack<=0.
  - Wait until req[winner]=0, then return to IDLE. A held req never causes a double write.
- unlock outside IDLE is ignored. Software retries.
- Latency: req rises before edge E0 -> gnt visible after E0 -> ack/nack and Data_out update visible after E1 + 1 (same cycle as ack/nack).
- Minimum 4 cycles per transaction, including RELEASE with an immediate req drop.
- Fairness: with all req held and cycling, grants rotate 0,1,2,3,0,...
- Other requesters' req are ignored while busy=1.
- At most one bit set across gnt|ack|nack in any cycle.

Test Plan:
- Single write, unlocked: reset, req[1]=1, wdata[1]=16'hA5A4 -> gnt=4'b0010 one cycle, then ack[1] pulse; Data_out=16'hA5A4, locked=0.
- Lock then refuse:
  - req[0] with 16'h1235 -> ack[0]; Data_out=16'h1235, locked=1.
  - Then req[2] with 16'hFFFE -> nack[2]; Data_out stays 16'h1235.
- Round-robin: req=4'b1111 held; each requester drops req after its ack and reasserts -> grant order 0,1,2,3,0; no requester granted twice consecutively while others wait.
- Unlock priority: while locked with Data_out=16'h00F1, unlock=1 and req[3]=1 in the same IDLE cycle -> Data_out=16'h00F0, locked=0; next cycle gnt[3]; write 16'h0002 -> ack[3], Data_out=16'h0002.
- Abandon: req[1] drops in GRANT cycle -> no ack/nack; Data_out unchanged; next arbitration starts from pointer=2.
- Reset mid-op: ip_reset=1 during COMMIT cycle -> next cycle all outputs 0, busy=0, no ack pulse.
